// File: rtl/ram_banked.sv
// ram_banked: parametrised single-port synchronous RAM split into
// 2**BANK_BITS banks, with a req/ready handshake, a registered read
// (out/out_valid) and a hardware zero-fill sweep after every reset.
// Optional feature macro: RAM_BANKED_PARITY_EN adds one even-parity bit per
// word and a parity_err output registered alongside out.
module ram_banked #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    parameter int BANK_BITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    output logic              ready,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
`ifdef RAM_BANKED_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int NBANKS     = 2 ** BANK_BITS;
    localparam int OFF_W      = ADDR_W - BANK_BITS;
    localparam int BANK_DEPTH = 2 ** OFF_W;
    // A single-bank build still needs a 1-bit select signal.
    localparam int BSEL_W     = (BANK_BITS == 0) ? 1 : BANK_BITS;
`ifdef RAM_BANKED_PARITY_EN
    localparam int MEM_W      = DATA_W + 1;
`else
    localparam int MEM_W      = DATA_W;
`endif

    typedef enum logic {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_sweep;
    logic [ADDR_W-1:0]   w_sweep_nxt;

    logic                w_ready;
    logic                w_acc;
    logic                w_wr;
    logic                w_rd;
    logic                w_init;

    logic [BSEL_W-1:0]   w_rbank;
    logic [OFF_W-1:0]    w_roff;
    logic [BSEL_W-1:0]   w_wbank;
    logic [OFF_W-1:0]    w_woff;
    logic                w_we;
    logic [MEM_W-1:0]    w_wdata;
    logic [MEM_W-1:0]    w_bank_rd [NBANKS];
    logic [MEM_W-1:0]    w_rword;

    logic [DATA_W-1:0]   r_out;
    logic                r_out_valid;

    assign w_ready = (r_state == S_IDLE);
    assign w_init  = (r_state == S_INIT);
    assign w_acc   = req & w_ready;
    assign w_wr    = w_acc & load;
    assign w_rd    = w_acc & ~load;

    // Request address split into bank select (MSBs) and in-bank offset.
    assign w_rbank = BSEL_W'(address >> OFF_W);
    assign w_roff  = address[OFF_W-1:0];

    // The sweep owns the write port during INIT; requests are ignored there.
    // Writes are suppressed while rst_n is low so reset alone never alters
    // memory contents.
    assign w_wbank = w_init ? BSEL_W'(r_sweep >> OFF_W) : w_rbank;
    assign w_woff  = w_init ? r_sweep[OFF_W-1:0] : w_roff;
    assign w_we    = rst_n & (w_init | w_wr);
`ifdef RAM_BANKED_PARITY_EN
    assign w_wdata = w_init ? '0 : {^in, in};
`else
    assign w_wdata = w_init ? '0 : in;
`endif

    genvar gb;
    generate
        for (gb = 0; gb < NBANKS; gb++) begin : g_bank
            logic [MEM_W-1:0] r_bank [BANK_DEPTH];

            // Bank storage: only the bank selected by the write address is enabled.
            always_ff @(posedge clk) begin
                if (w_we && (w_wbank == BSEL_W'(gb)))
                    r_bank[w_woff] <= w_wdata;
            end

            assign w_bank_rd[gb] = r_bank[w_roff];
        end
    endgenerate

    assign w_rword = w_bank_rd[w_rbank];

    // FSM state and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    // Next-state logic: sweep every word once, then sit in IDLE until reset.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        case (r_state)
            S_INIT: begin
                w_sweep_nxt = r_sweep + 1'b1;
                if (r_sweep == ADDR_W'(DEPTH - 1))
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_INIT;
                w_sweep_nxt = '0;
            end
        endcase
    end

    // Registered read port: out holds until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_rd;
            if (w_rd)
                r_out <= w_rword[DATA_W-1:0];
        end
    end

`ifdef RAM_BANKED_PARITY_EN
    logic r_parity_err;

    // Parity check registered with the read data; it never blocks the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_parity_err <= 1'b0;
        else if (w_rd)
            r_parity_err <= w_rword[DATA_W] ^ (^w_rword[DATA_W-1:0]);
    end

    assign parity_err = r_parity_err;
`endif

    assign ready     = w_ready;
    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_ram_banked.sv
// Directed testbench for ram_banked with default parameters (512 x 16, 8 banks).
module tb_ram_banked;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        load;
    logic [8:0]  address;
    logic [15:0] in_d;
    logic        ready;
    logic [15:0] out;
    logic        out_valid;
`ifdef RAM_BANKED_PARITY_EN
    logic        parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ram_banked #(.DATA_W(16), .ADDR_W(9), .BANK_BITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .load      (load),
        .address   (address),
        .in        (in_d),
        .ready     (ready),
        .out       (out),
        .out_valid (out_valid)
`ifdef RAM_BANKED_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        load;
        logic [8:0]  addr;
        logic [15:0] data;
        logic        exp_v;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic l, input logic [8:0] a,
                           input logic [15:0] d, input logic ev, input logic [15:0] eo);
        vec_t v;
        v.req = r; v.load = l; v.addr = a; v.data = d; v.exp_v = ev; v.exp_out = eo;
        vecs.push_back(v);
    endtask

    // Drive one request at the falling edge, return 1 ns after the rising edge.
    task automatic apply(input logic r, input logic l, input logic [8:0] a, input logic [15:0] d);
        @(negedge clk);
        req = r; load = l; address = a; in_d = d;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    // Count rising edges until ready; call with rst_n already released,
    // away from a rising edge. Optionally injects requests during INIT.
    task automatic wait_init(input bit inject, output int cnt, output bit sawv);
        bit done;
        cnt  = 0;
        sawv = 1'b0;
        done = 1'b0;
        while (!done && cnt < 2000) begin
            req = 1'b0; load = 1'b0; address = '0; in_d = '0;
            if (inject) begin
                if (cnt == 10)  begin req = 1'b1; load = 1'b1; address = 9'h1FF; in_d = 16'hDEAD; end
                if (cnt == 300) begin req = 1'b1; load = 1'b1; address = 9'h005; in_d = 16'hBEEF; end
                if (cnt == 301) begin req = 1'b1; load = 1'b0; address = 9'h005; end
            end
            @(posedge clk);
            #1;
            cnt++;
            if (out_valid === 1'b1) sawv = 1'b1;
            if (ready === 1'b1) done = 1'b1;
            else @(negedge clk);
        end
        req = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  sawv;
        logic [8:0]  a;
        logic [15:0] d;

        rst_n = 1'b0; req = 1'b0; load = 1'b0; address = '0; in_d = '0;

        // Reset state
        #2;
        chk("reset_ready", ready, 0);
        chk("reset_out", out, 0);
        chk("reset_out_valid", out_valid, 0);

        // INIT length after release
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(1'b0, cnt, sawv);
        chk("init_edges", cnt, 512);
        chk("init_no_valid", sawv, 0);

        // Table-driven sequence: zero reads, bank isolation, hold behaviour.
        add_vec(1, 0, 9'h000, 16'h0000, 1, 16'h0000);
        add_vec(1, 0, 9'h0FF, 16'h0000, 1, 16'h0000);
        add_vec(1, 0, 9'h1FF, 16'h0000, 1, 16'h0000);
        add_vec(1, 1, 9'h041, 16'hBEEF, 0, 16'h0000);
        add_vec(1, 0, 9'h041, 16'h0000, 1, 16'hBEEF);
        add_vec(1, 0, 9'h001, 16'h0000, 1, 16'h0000);
        add_vec(0, 0, 9'h041, 16'h0000, 0, 16'h0000);
        add_vec(1, 0, 9'h041, 16'h0000, 1, 16'hBEEF);
        add_vec(0, 0, 9'h000, 16'h0000, 0, 16'hBEEF);
        add_vec(1, 1, 9'h1FF, 16'h1234, 0, 16'hBEEF);
        add_vec(1, 0, 9'h1FF, 16'h0000, 1, 16'h1234);
        add_vec(1, 0, 9'h0C1, 16'h0000, 1, 16'h0000);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].req, vecs[i].load, vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_v);
            chk($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
        end

        // Alternating write/read every cycle across all 8 banks.
        for (int k = 0; k < 8; k++) begin
            a = 9'(k * 64 + k + 3);
            d = 16'(a) ^ 16'hA5A5;
            apply(1, 1, a, d);
            chk($sformatf("alt%0d_wr_valid", k), out_valid, 0);
            apply(1, 0, a, 16'h0000);
            chk($sformatf("alt%0d_rd_valid", k), out_valid, 1);
            chk($sformatf("alt%0d_rd_out", k), out, d);
        end

        // Reset pulse at INIT cycle 100, then requests ignored during INIT.
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midinit_ready", ready, 0);
        chk("midinit_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(1'b1, cnt, sawv);
        chk("reinit_edges", cnt, 512);
        chk("reinit_no_valid", sawv, 0);
        apply(1, 0, 9'h1FF, 16'h0000);
        chk("ignored_wr_1ff_valid", out_valid, 1);
        chk("ignored_wr_1ff_out", out, 16'h0000);
        apply(1, 0, 9'h005, 16'h0000);
        chk("ignored_wr_005_out", out, 16'h0000);
        apply(1, 0, 9'h043, 16'h0000);
        chk("swept_043_out", out, 16'h0000);

        // Reset right after an accepted read discards the result.
        apply(1, 1, 9'h041, 16'hBEEF);
        apply(1, 0, 9'h041, 16'h0000);
        chk("pre_reset_rd_valid", out_valid, 1);
        chk("pre_reset_rd_out", out, 16'hBEEF);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out", out, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", ready, 0);
        @(posedge clk);
        #1;
        chk("post_rst_no_pulse", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(1'b0, cnt, sawv);
        chk("third_init_edges", cnt, 512);
        chk("third_init_no_valid", sawv, 0);

`ifdef RAM_BANKED_PARITY_EN
        // Parity: corrupt the stored parity bit of word 1 (bank 0, offset 1).
        apply(1, 1, 9'h001, 16'h0001);
        @(negedge clk);
        dut.g_bank[0].r_bank[1][16] = ~dut.g_bank[0].r_bank[1][16];
        apply(1, 0, 9'h001, 16'h0000);
        chk("par_bad_out", out, 16'h0001);
        chk("par_bad_err", parity_err, 1);
        apply(1, 1, 9'h003, 16'h0003);
        apply(1, 0, 9'h003, 16'h0000);
        chk("par_good_out", out, 16'h0003);
        chk("par_good_err", parity_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
